// File: rtl/trk_pkg.sv
// trk_pkg: shared state encoding, record layout and drop-counter helpers for the tracker event collector.
package trk_pkg;
   localparam int DROP_CNT_W = 16;
   localparam int REC_CH_W   = 4;
   localparam int REC_TS_W   = 32;
   localparam int REC_DATA_W = 32;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} trk_state_e;
   typedef struct packed {
      logic [REC_CH_W-1:0]   ch;
      logic [REC_TS_W-1:0]   ts;
      logic [REC_DATA_W-1:0] data;
   } trk_rec_t;
   function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a, input logic [4:0] b);
      logic [DROP_CNT_W:0] s;
      s = {1'b0, a} + {{(DROP_CNT_W-4){1'b0}}, b};
      return s[DROP_CNT_W] ? '1 : s[DROP_CNT_W-1:0];
   endfunction
endpackage

// File: rtl/trk_fifo.sv
// trk_fifo: synchronous FIFO, extra-bit pointers resolve full/empty; head word is read combinationally.
module trk_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             last
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wp_q, rp_q, used;
   logic do_push, do_pop;
   assign used    = wp_q - rp_q;
   assign empty   = used == '0;
   assign full    = used[AW];
   assign last    = used == (AW+1)'(1);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rp_q[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_q + (AW+1)'(do_push);
         rp_q <= rp_q + (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/trk_event_collector.sv
// trk_event_collector: per-channel hold registers capture tracker events, a round-robin arbiter
// drains them into a FIFO, and a small FSM sequences run, flush and done.
module trk_event_collector
   import trk_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int DATA_W      = 32,
   parameter  int CYCLE_CNT_W = 32,
   parameter  int DEPTH       = 8,
   localparam int CH_W        = NUM_CH > 1 ? $clog2(NUM_CH) : 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     test_undone,
   input  logic [CYCLE_CNT_W-1:0]   cycle_count,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic [CYCLE_CNT_W-1:0]   out_ts,
   output logic [DATA_W-1:0]        out_data,
   output logic [DROP_CNT_W-1:0]    drop_cnt,
   output logic                     overflow,
   output logic                     done
);
   typedef struct packed {
      logic [CH_W-1:0]        ch;
      logic [CYCLE_CNT_W-1:0] ts;
      logic [DATA_W-1:0]      data;
   } rec_t;
   trk_state_e state_q, state_d;
   rec_t hold_q [NUM_CH];
   rec_t hold_d [NUM_CH];
   rec_t head;
   logic [NUM_CH-1:0] hv_q, hv_d, cap, drop;
   logic [CH_W-1:0] rr_q, gnt, idx;
   logic gnt_v, pop, empty, full, last, ovf_q;
   logic [DROP_CNT_W-1:0] drop_cnt_q;
   logic [4:0] n_drop;
   assign pop = !empty && out_ready;
   // lowest offset from rr_q wins; a grant needs room in the FIFO, counting a same-cycle pop
   always_comb begin
      gnt_v = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         idx = CH_W'((int'(rr_q) + k) % NUM_CH);
         if (hv_q[idx]) begin
            gnt_v = 1'b1;
            gnt   = idx;
         end
      end
      gnt_v = gnt_v && (!full || pop);
   end
   always_comb begin
      hv_d   = hv_q;
      hold_d = hold_q;
      cap    = '0;
      drop   = '0;
      n_drop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cap[i]  = state_q == RUN && enable && ch_valid[i];
         drop[i] = cap[i] && hv_q[i] && !(gnt_v && gnt == CH_W'(i));
         if (gnt_v && gnt == CH_W'(i)) hv_d[i] = 1'b0;
         if (cap[i] && !drop[i]) begin
            hv_d[i]   = 1'b1;
            hold_d[i] = '{ch: CH_W'(i), ts: cycle_count, data: ch_data[i*DATA_W +: DATA_W]};
         end
         n_drop = n_drop + 5'(drop[i]);
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = enable && test_undone ? RUN : IDLE;
         RUN:     state_d = !test_undone ? FLUSH : RUN;
         FLUSH:   state_d = hv_q == '0 && (empty || (last && pop)) ? DONE : FLUSH;
         default: state_d = state_q;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         hv_q       <= '0;
         rr_q       <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hv_q       <= hv_d;
         drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
         ovf_q      <= ovf_q || n_drop != '0;
         if (gnt_v) rr_q <= CH_W'((int'(gnt) + 1) % NUM_CH);
      end
   always_ff @(posedge clk)
      hold_q <= hold_d;
   trk_fifo #(.WIDTH($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (gnt_v),
      .pop   (pop),
      .wdata (hold_q[gnt]),
      .rdata (head),
      .empty (empty),
      .full  (full),
      .last  (last)
   );
   // record fields read as zero whenever nothing is valid, including during reset
   assign out_valid = !empty;
   assign out_ch    = out_valid ? head.ch : '0;
   assign out_ts    = out_valid ? head.ts : '0;
   assign out_data  = out_valid ? head.data : '0;
   assign drop_cnt  = drop_cnt_q;
   assign overflow  = ovf_q;
   assign done      = state_q == DONE;
endmodule

// File: tb/tb_trk_event_collector.sv
// tb_trk_event_collector: vector table, directed corner sequences and a queue-based reference model
// compared cycle by cycle against randomized traffic.
module tb_trk_event_collector;
   localparam int NCH = 4, DW = 32, CW = 32, DEPTH = 8;
   localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DONE = 3;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, test_undone = 1'b0, out_ready = 1'b0;
   logic [CW-1:0] cycle_count = '0;
   logic [NCH-1:0] ch_valid = '0;
   logic [NCH*DW-1:0] ch_data = '0;
   logic out_valid, overflow, done;
   logic [1:0] out_ch;
   logic [CW-1:0] out_ts;
   logic [DW-1:0] out_data;
   logic [15:0] drop_cnt;
   int n_chk = 0, n_fail = 0;

   trk_event_collector #(.NUM_CH(NCH), .DATA_W(DW), .CYCLE_CNT_W(CW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .test_undone(test_undone),
      .cycle_count(cycle_count), .ch_valid(ch_valid), .ch_data(ch_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_ts(out_ts),
      .out_data(out_data), .drop_cnt(drop_cnt), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [NCH-1:0] cv, input int cc, input logic [31:0] d);
      ch_valid    = cv;
      cycle_count = CW'(cc);
      for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = d + 32'(i);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b0; test_undone = 1'b0; out_ready = 1'b0;
      drive('0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1; test_undone = 1'b1;
   endtask

   // reference model: FIFO as a queue, holds as an array, priority pointer as an integer
   typedef struct { int ch; logic [CW-1:0] ts; logic [DW-1:0] d; } mrec_t;
   mrec_t mq[$];
   mrec_t mh[NCH];
   bit mhv[NCH];
   int mrr, mst, mdrop;
   bit movf;

   task automatic mreset();
      mq.delete();
      for (int i = 0; i < NCH; i++) mhv[i] = 0;
      mrr = 0; mst = M_IDLE; mdrop = 0; movf = 0;
   endtask

   task automatic mstep();
      int g;
      bit pop, can;
      pop = mq.size() != 0 && out_ready;
      can = mq.size() < DEPTH || pop;
      g = -1;
      if (can)
         for (int k = 0; k < NCH; k++)
            if (mhv[(mrr + k) % NCH]) begin
               g = (mrr + k) % NCH;
               break;
            end
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
         mq.push_back(mh[g]);
         mhv[g] = 0;
         mrr = (g + 1) % NCH;
      end
      if (mst == M_RUN && enable)
         for (int i = 0; i < NCH; i++)
            if (ch_valid[i]) begin
               if (mhv[i]) begin
                  mdrop++;
                  movf = 1;
               end else begin
                  mhv[i] = 1;
                  mh[i] = '{i, cycle_count, ch_data[i*DW +: DW]};
               end
            end
      if (mst == M_IDLE && enable && test_undone) mst = M_RUN;
      else if (mst == M_RUN && !test_undone) mst = M_FLUSH;
      else if (mst == M_FLUSH) begin
         bit any;
         any = mq.size() != 0;
         for (int i = 0; i < NCH; i++) any |= mhv[i];
         if (!any) mst = M_DONE;
      end
   endtask

   task automatic cmp_model();
      chk("rnd_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("rnd_ch", out_ch, mq[0].ch);
         chk("rnd_ts", out_ts, mq[0].ts);
         chk("rnd_data", out_data, mq[0].d);
      end
      chk("rnd_drop", drop_cnt, mdrop > 65535 ? 65535 : mdrop);
      chk("rnd_ovf", overflow, movf);
      chk("rnd_done", done, mst == M_DONE);
   endtask

   typedef struct {
      logic [3:0] cv; int cc; logic [31:0] d;
      logic ev; logic [1:0] ech; int ets; logic [31:0] ed;
   } vec_t;
   vec_t tbl[12];

   initial begin
      bit fin;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_ch", out_ch, 0);
      chk("rst_ts", out_ts, 0);
      chk("rst_data", out_data, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_done", done, 0);

      // burst on all channels, then a ch0 event on the hold being granted, then a lone event
      tbl[0]  = '{4'b0000,   0, 32'h00, 0, 0,   0, 32'h00};
      tbl[1]  = '{4'b1111, 200, 32'h10, 0, 0,   0, 32'h00};
      tbl[2]  = '{4'b0001, 201, 32'h20, 0, 0,   0, 32'h00};
      tbl[3]  = '{4'b0000,   0, 32'h00, 1, 0, 200, 32'h10};
      tbl[4]  = '{4'b0000,   0, 32'h00, 1, 1, 200, 32'h11};
      tbl[5]  = '{4'b0000,   0, 32'h00, 1, 2, 200, 32'h12};
      tbl[6]  = '{4'b0000,   0, 32'h00, 1, 3, 200, 32'h13};
      tbl[7]  = '{4'b0000,   0, 32'h00, 1, 0, 201, 32'h20};
      tbl[8]  = '{4'b0001, 100, 32'hA5, 0, 0,   0, 32'h00};
      tbl[9]  = '{4'b0000,   0, 32'h00, 0, 0,   0, 32'h00};
      tbl[10] = '{4'b0000,   0, 32'h00, 1, 0, 100, 32'hA5};
      tbl[11] = '{4'b0000,   0, 32'h00, 0, 0,   0, 32'h00};
      do_reset();
      out_ready = 1'b1;
      for (int r = 0; r < 12; r++) begin
         chk($sformatf("vec%0d_valid", r), out_valid, tbl[r].ev);
         if (tbl[r].ev) begin
            chk($sformatf("vec%0d_ch", r), out_ch, tbl[r].ech);
            chk($sformatf("vec%0d_ts", r), out_ts, tbl[r].ets);
            chk($sformatf("vec%0d_data", r), out_data, tbl[r].ed);
         end else chk($sformatf("vec%0d_ts_zero", r), out_ts, 0);
         chk($sformatf("vec%0d_drop", r), drop_cnt, 0);
         drive(tbl[r].cv, tbl[r].cc, tbl[r].d);
         @(negedge clk);
      end

      // backpressure: 8 in FIFO, 1 in hold, 3 dropped
      do_reset();
      @(negedge clk);
      for (int k = 1; k <= 12; k++) begin
         drive(4'b0001, 1000 + k, k);
         @(negedge clk);
      end
      drive('0, 0, 0);
      chk("bp_drop", drop_cnt, 3);
      chk("bp_ovf", overflow, 1);
      chk("bp_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         chk($sformatf("bp_rec%0d_valid", j), out_valid, 1);
         chk($sformatf("bp_rec%0d_ts", j), out_ts, 1000 + j);
         chk($sformatf("bp_rec%0d_data", j), out_data, j);
         @(negedge clk);
      end
      chk("bp_empty", out_valid, 0);

      // saturation: 24 drops while the FIFO fills, then 4 per cycle
      do_reset();
      @(negedge clk);
      drive(4'b1111, 7, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("sat_fill_drop", drop_cnt, 24);
      repeat (16386 - 9) @(posedge clk);
      @(negedge clk);
      chk("sat_pre", drop_cnt, 65532);
      @(negedge clk);
      chk("sat_cross", drop_cnt, 16'hFFFF);
      @(negedge clk);
      chk("sat_hold", drop_cnt, 16'hFFFF);
      chk("sat_ovf", overflow, 1);
      drive('0, 0, 0);

      // flush: 5 pending records drain, capture ignored, done right after last pop
      do_reset();
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         drive(4'b0001, 300 + k, k);
         @(negedge clk);
      end
      drive('0, 0, 0);
      repeat (3) @(negedge clk);
      chk("fl_pending", out_valid, 1);
      test_undone = 1'b0;
      @(negedge clk);
      drive(4'b1111, 999, 32'hEE);
      @(negedge clk);
      drive('0, 0, 0);
      out_ready = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         chk($sformatf("fl_rec%0d_ts", j), out_ts, 300 + j);
         chk($sformatf("fl_rec%0d_done", j), done, 0);
         @(negedge clk);
      end
      chk("fl_done", done, 1);
      chk("fl_empty", out_valid, 0);

      // mid-operation reset discards pending records
      do_reset();
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         drive(4'b0001, 500 + k, k);
         @(negedge clk);
      end
      drive('0, 0, 0);
      repeat (3) @(negedge clk);
      chk("mr_pending", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_async_valid", out_valid, 0);
      chk("mr_async_ts", out_ts, 0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("mr_stale%0d", j), out_valid, 0);
         @(negedge clk);
      end

      // randomized traffic against the model, then flush to done
      do_reset();
      mreset();
      for (int c = 0; c < 3000; c++) begin
         cmp_model();
         enable      = $urandom_range(0, 9) != 0;
         out_ready   = $urandom_range(0, 99) < (c < 1500 ? 90 : 40);
         ch_valid    = NCH'($urandom & $urandom);
         cycle_count = cycle_count + 1;
         ch_data     = {$urandom, $urandom, $urandom, $urandom};
         mstep();
         @(negedge clk);
      end
      test_undone = 1'b0;
      fin = 0;
      for (int c = 0; c < 300 && !fin; c++) begin
         cmp_model();
         if (mst == M_DONE) fin = 1;
         else begin
            out_ready   = $urandom_range(0, 1);
            ch_valid    = NCH'($urandom);
            cycle_count = cycle_count + 1;
            mstep();
            @(negedge clk);
         end
      end
      chk("rnd_flush_done", done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
